// File: rtl/range_arb_pkg.sv
// Shared types for the range-finder session arbiter: FSM states and result status codes.
package range_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FIRST,
        REPEAT,
        STREAM,
        DRAIN,
        CAPTURE
    } arb_state_e;

    localparam int STATUS_W = 2;

    typedef enum logic [STATUS_W-1:0] {
        STATUS_OK      = 2'd0,
        STATUS_ABORT   = 2'd1,
        STATUS_TIMEOUT = 2'd2,
        STATUS_RF_ERR  = 2'd3
    } arb_status_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester after ptr_i.
module rr_arbiter
    import range_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    // The pointer itself is searched last, so the previous owner has lowest priority.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/range_session_arbiter.sv
// Shares one range finder between N_REQ sample streams, one session at a time, round-robin.
// Optional session length limit compiled in with RANGE_ARB_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | no owner; grant the round-robin winner when any req is high
// WAIT_FIRST | owner granted; first sample issues rf_go
// REPEAT     | one-sample (or early-abort) session; issue rf_finish on held data
// STREAM     | forwarding owner samples to the finder
// DRAIN      | finish strobe done; let the finder settle its range
// CAPTURE    | latch range, publish result, release grant
module range_session_arbiter
    import range_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 10,
    parameter int MAX_LEN = 255
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       sample_valid,
    input  logic [N_REQ-1:0]       sample_last,
    input  logic [N_REQ*WIDTH-1:0] sample_data,
    output logic [N_REQ-1:0]       grant,
    output logic [WIDTH-1:0]       rf_data_in,
    output logic                   rf_go,
    output logic                   rf_finish,
    input  logic [WIDTH-1:0]       rf_range,
    input  logic                   rf_error,
    output logic                   result_valid,
    output logic [WIDTH-1:0]       result_range,
    output logic [$clog2(N_REQ)-1:0] result_id,
    output logic [STATUS_W-1:0]    result_status
);

    localparam int IDW = $clog2(N_REQ);

    arb_state_e           state_q;
    logic [N_REQ-1:0]     grant_q;
    logic [IDW-1:0]       owner_q;
    logic [IDW-1:0]       ptr_q;
    logic [WIDTH-1:0]     rf_data_q;
    logic                 rf_go_q;
    logic                 rf_finish_q;
    logic                 abort_q;
    logic                 timeout_q;
    logic                 result_valid_q;
    logic [WIDTH-1:0]     result_range_q;
    logic [IDW-1:0]       result_id_q;
    logic [STATUS_W-1:0]  result_status_q;

    logic [N_REQ-1:0]     win_gnt;
    logic [IDW-1:0]       win_idx;
    logic                 own_req;
    logic                 own_valid;
    logic                 own_last;
    logic [WIDTH-1:0]     own_data;
    logic                 timeout_hit;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (IDW)
    ) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (win_gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_gnt[i]) win_idx = IDW'(i);
        end
    end

    // Only the owner's lanes are ever looked at; other requesters' samples are dropped.
    always_comb begin
        own_req   = req[owner_q];
        own_valid = sample_valid[owner_q];
        own_last  = sample_last[owner_q];
        own_data  = sample_data[int'(owner_q)*WIDTH +: WIDTH];
    end

`ifdef RANGE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    logic [CNT_W-1:0] len_q;
    logic             stream_exit;

    assign timeout_hit = (state_q == STREAM) && (len_q == CNT_W'(MAX_LEN - 1));
    assign stream_exit = !own_req || (own_valid && own_last) || timeout_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_q <= '0;
        end else if (state_q == STREAM && !stream_exit) begin
            len_q <= len_q + 1'b1;
        end else begin
            len_q <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            owner_q         <= '0;
            ptr_q           <= IDW'(N_REQ - 1);
            rf_data_q       <= '0;
            rf_go_q         <= 1'b0;
            rf_finish_q     <= 1'b0;
            abort_q         <= 1'b0;
            timeout_q       <= 1'b0;
            result_valid_q  <= 1'b0;
            result_range_q  <= '0;
            result_id_q     <= '0;
            result_status_q <= '0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q   <= win_gnt;
                        owner_q   <= win_idx;
                        abort_q   <= 1'b0;
                        timeout_q <= 1'b0;
                        state_q   <= WAIT_FIRST;
                    end
                end
                WAIT_FIRST: begin
                    if (!own_req) begin
                        // The finder still needs a go before finish, so start it on zero data.
                        rf_data_q <= '0;
                        rf_go_q   <= 1'b1;
                        abort_q   <= 1'b1;
                        state_q   <= REPEAT;
                    end else if (own_valid) begin
                        rf_data_q <= own_data;
                        rf_go_q   <= 1'b1;
                        state_q   <= own_last ? REPEAT : STREAM;
                    end
                end
                REPEAT: begin
                    rf_go_q     <= 1'b0;
                    rf_finish_q <= 1'b1;
                    state_q     <= DRAIN;
                end
                STREAM: begin
                    rf_go_q <= 1'b0;
                    if (!own_req) begin
                        rf_finish_q <= 1'b1;
                        abort_q     <= 1'b1;
                        state_q     <= DRAIN;
                    end else begin
                        if (own_valid) rf_data_q <= own_data;
                        if (own_valid && own_last) begin
                            rf_finish_q <= 1'b1;
                            state_q     <= DRAIN;
                        end else if (timeout_hit) begin
                            rf_finish_q <= 1'b1;
                            timeout_q   <= 1'b1;
                            state_q     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    rf_finish_q <= 1'b0;
                    state_q     <= CAPTURE;
                end
                CAPTURE: begin
                    result_range_q <= rf_range;
                    result_id_q    <= owner_q;
                    result_valid_q <= 1'b1;
                    if (rf_error)       result_status_q <= STATUS_RF_ERR;
                    else if (timeout_q) result_status_q <= STATUS_TIMEOUT;
                    else if (abort_q)   result_status_q <= STATUS_ABORT;
                    else                result_status_q <= STATUS_OK;
                    ptr_q   <= owner_q;
                    grant_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant         = grant_q;
    assign rf_data_in    = rf_data_q;
    assign rf_go         = rf_go_q;
    assign rf_finish     = rf_finish_q;
    assign result_valid  = result_valid_q;
    assign result_range  = result_range_q;
    assign result_id     = result_id_q;
    assign result_status = result_status_q;

endmodule

// File: tb/tb_range_session_arbiter.sv
// Directed bench for range_session_arbiter with a max-minus-min range-finder model.
module tb_range_session_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 10;
`ifdef RANGE_ARB_TIMEOUT_EN
    localparam int MAX_LEN = 8;
`else
    localparam int MAX_LEN = 255;
`endif

    logic                   clock;
    logic                   reset_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       sample_valid;
    logic [N_REQ-1:0]       sample_last;
    logic [N_REQ*WIDTH-1:0] sample_data;
    logic [N_REQ-1:0]       grant;
    logic [WIDTH-1:0]       rf_data_in;
    logic                   rf_go;
    logic                   rf_finish;
    logic [WIDTH-1:0]       rf_range;
    logic                   rf_error;
    logic                   result_valid;
    logic [WIDTH-1:0]       result_range;
    logic [1:0]             result_id;
    logic [1:0]             result_status;

    range_session_arbiter #(
        .N_REQ   (N_REQ),
        .WIDTH   (WIDTH),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req           (req),
        .sample_valid  (sample_valid),
        .sample_last   (sample_last),
        .sample_data   (sample_data),
        .grant         (grant),
        .rf_data_in    (rf_data_in),
        .rf_go         (rf_go),
        .rf_finish     (rf_finish),
        .rf_range      (rf_range),
        .rf_error      (rf_error),
        .result_valid  (result_valid),
        .result_range  (result_range),
        .result_id     (result_id),
        .result_status (result_status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Range-finder model: range = max - min of every cycle's data from go through finish.
    logic [WIDTH-1:0] mn_q, mx_q, rng_q, nmn, nmx;
    logic             act_q;
    assign rf_range = rng_q;

    always @(posedge clock) begin
        if (!reset_n) begin
            act_q <= 1'b0;
            rng_q <= '0;
            mn_q  <= '0;
            mx_q  <= '0;
        end else if (rf_go) begin
            mn_q  <= rf_data_in;
            mx_q  <= rf_data_in;
            act_q <= 1'b1;
        end else if (act_q) begin
            nmn = (rf_data_in < mn_q) ? rf_data_in : mn_q;
            nmx = (rf_data_in > mx_q) ? rf_data_in : mx_q;
            mn_q <= nmn;
            mx_q <= nmx;
            if (rf_finish) begin
                rng_q <= nmx - nmn;
                act_q <= 1'b0;
            end
        end
    end

    int cyc = 0, go_cnt = 0, fin_cnt = 0, both_cnt = 0, go_cyc = 0, fin_cyc = 0;
    int res_cnt = 0, res_cyc = 0;
    int res_range_log [64];
    int res_id_log    [64];
    int res_st_log    [64];

    always @(posedge clock) begin
        cyc++;
        if (rf_go) begin go_cnt++; go_cyc = cyc; end
        if (rf_finish) begin fin_cnt++; fin_cyc = cyc; end
        if (rf_go && rf_finish) both_cnt++;
        if (result_valid) begin
            res_range_log[res_cnt % 64] = int'(result_range);
            res_id_log[res_cnt % 64]    = int'(result_id);
            res_st_log[res_cnt % 64]    = int'(result_status);
            res_cnt++;
            res_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [N_REQ-1:0] noise;

    task automatic send(input int id, input logic [WIDTH-1:0] d, input bit last);
        sample_valid = N_REQ'(1 << id) | noise;
        sample_last  = last ? N_REQ'(1 << id) : '0;
        sample_data[id*WIDTH +: WIDTH] = d;
        tick();
        sample_valid = '0;
        sample_last  = '0;
    endtask

    task automatic wait_result(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (res_cnt >= target) break;
            tick();
        end
        check_eq("result_arrived", 32'(res_cnt >= target), 32'd1);
    endtask

    task automatic do_reset();
        req = '0; sample_valid = '0; sample_last = '0; sample_data = '0;
        rf_error = 1'b0; noise = '0;
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int g0, f0, r0, last_cyc;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        req = '0; sample_valid = '0; sample_last = '0; sample_data = '0;
        rf_error = 1'b0; noise = '0;
        reset_n = 1'b0;
        tick(); tick();
        check_eq("rst_grant",  32'(grant), 32'd0);
        check_eq("rst_go",     32'(rf_go), 32'd0);
        check_eq("rst_finish", 32'(rf_finish), 32'd0);
        check_eq("rst_data",   32'(rf_data_in), 32'd0);
        check_eq("rst_rvalid", 32'(result_valid), 32'd0);
        check_eq("rst_range",  32'(result_range), 32'd0);
        check_eq("rst_id",     32'(result_id), 32'd0);
        check_eq("rst_status", 32'(result_status), 32'd0);
        reset_n = 1'b1;
        tick();

        // Normal session on requester 1, with requester 3 strobing junk it does not own.
        noise = 4'b1000;
        sample_data[3*WIDTH +: WIDTH] = 10'd1000;
        req = 4'b0010;
        tick();
        check_eq("norm_grant", 32'(grant), 32'b0010);
        g0 = go_cnt; f0 = fin_cnt; r0 = res_cnt;
        send(1, 10'd5, 1'b0);
        send(1, 10'd9, 1'b0);
        send(1, 10'd3, 1'b0);
        send(1, 10'd7, 1'b1);
        last_cyc = cyc;
        req = '0; noise = '0;
        wait_result(r0 + 1, 20);
        check_eq("norm_latency", 32'(res_cyc - last_cyc), 32'd3);
        check_eq("norm_range",   32'(res_range_log[r0 % 64]), 32'd6);
        check_eq("norm_id",      32'(res_id_log[r0 % 64]), 32'd1);
        check_eq("norm_status",  32'(res_st_log[r0 % 64]), 32'd0);
        check_eq("norm_go_cnt",  32'(go_cnt - g0), 32'd1);
        check_eq("norm_fin_cnt", 32'(fin_cnt - f0), 32'd1);
        check_eq("norm_release", 32'(grant), 32'd0);

        // One-sample session takes the REPEAT path.
        tick();
        req = 4'b0100;
        tick();
        check_eq("one_grant", 32'(grant), 32'b0100);
        r0 = res_cnt;
        send(2, 10'd12, 1'b1);
        last_cyc = cyc;
        req = '0;
        wait_result(r0 + 1, 20);
        check_eq("one_latency",  32'(res_cyc - last_cyc), 32'd4);
        check_eq("one_go_to_fin", 32'(fin_cyc - go_cyc), 32'd1);
        check_eq("one_range",    32'(res_range_log[r0 % 64]), 32'd0);
        check_eq("one_id",       32'(res_id_log[r0 % 64]), 32'd2);
        check_eq("one_status",   32'(res_st_log[r0 % 64]), 32'd0);

        // Requester 0 walks away mid-stream.
        tick();
        req = 4'b0001;
        tick();
        check_eq("abort_grant", 32'(grant), 32'b0001);
        r0 = res_cnt;
        send(0, 10'd4, 1'b0);
        send(0, 10'd8, 1'b0);
        req = '0;
        tick();
        check_eq("abort_finish", 32'(rf_finish), 32'd1);
        wait_result(r0 + 1, 20);
        check_eq("abort_status", 32'(res_st_log[r0 % 64]), 32'd1);
        check_eq("abort_id",     32'(res_id_log[r0 % 64]), 32'd0);
        check_eq("abort_range",  32'(res_range_log[r0 % 64]), 32'd4);
        check_eq("abort_release", 32'(grant), 32'd0);

        // Finder error overrides everything; pointer is at 0 so requester 3 wins.
        tick();
        rf_error = 1'b1;
        req = 4'b1000;
        tick();
        check_eq("err_grant", 32'(grant), 32'b1000);
        r0 = res_cnt;
        send(3, 10'd10, 1'b0);
        send(3, 10'd20, 1'b1);
        req = '0;
        wait_result(r0 + 1, 20);
        rf_error = 1'b0;
        check_eq("err_status", 32'(res_st_log[r0 % 64]), 32'd3);
        check_eq("err_range",  32'(res_range_log[r0 % 64]), 32'd10);
        check_eq("err_id",     32'(res_id_log[r0 % 64]), 32'd3);

        // All four requesting continuously from reset: order 0,1,2,3,0.
        do_reset();
        r0 = res_cnt;
        sample_data  = {10'd4, 10'd3, 10'd2, 10'd1};
        sample_valid = 4'b1111;
        sample_last  = 4'b1111;
        req          = 4'b1111;
        wait_result(r0 + 5, 60);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("rr_order_%0d", k), 32'(res_id_log[(r0 + k) % 64]), 32'(exp_order[k]));
        end

        // Reset in the middle of a stream: everything clears, no result appears.
        do_reset();
        req = 4'b0010;
        tick();
        send(1, 10'd5, 1'b0);
        send(1, 10'd6, 1'b0);
        r0 = res_cnt;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_grant",  32'(grant), 32'd0);
        check_eq("mid_rst_data",   32'(rf_data_in), 32'd0);
        check_eq("mid_rst_go",     32'(rf_go), 32'd0);
        check_eq("mid_rst_finish", 32'(rf_finish), 32'd0);
        check_eq("mid_rst_rvalid", 32'(result_valid), 32'd0);
        req = '0;
        tick(); tick();
        reset_n = 1'b1;
        repeat (8) tick();
        check_eq("mid_rst_no_result", 32'(res_cnt), 32'(r0));

`ifdef RANGE_ARB_TIMEOUT_EN
        // Ten samples, no last: the 8th STREAM cycle forces finish after sample 9.
        do_reset();
        req = 4'b0100;
        tick();
        f0 = fin_cnt; r0 = res_cnt;
        for (int i = 1; i <= 10; i++) send(2, 10'(i * 3), 1'b0);
        req = '0;
        wait_result(r0 + 1, 20);
        check_eq("tmo_status",  32'(res_st_log[r0 % 64]), 32'd2);
        check_eq("tmo_range",   32'(res_range_log[r0 % 64]), 32'd24);
        check_eq("tmo_id",      32'(res_id_log[r0 % 64]), 32'd2);
        check_eq("tmo_fin_cnt", 32'(fin_cnt - f0), 32'd1);
`endif

        check_eq("go_finish_overlap", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
